// File: rtl/tx_fifo_serialiser_pkg.sv
// Shared Tx types: the FIFO entry, the serialiser state and the bit-count decode.
package tx_fifo_serialiser_pkg;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] bits;
  } tx_byte_t;

  localparam int TX_BYTE_W = $bits(tx_byte_t);

  typedef enum logic [1:0] {S_IDLE, S_BITS, S_PARITY} ser_state_e;

  // A bits field of zero encodes a full byte.
  function automatic logic [3:0] bits_to_count(input logic [2:0] bits);
    return (bits == 3'd0) ? 4'd8 : {1'b0, bits};
  endfunction

endpackage

// File: rtl/tx_fifo_serialiser_if.sv
// Byte-side push port and bit-side req handshake. master = frame generator / bit sink side, slave = serialiser.
interface tx_fifo_serialiser_if #(parameter int DEPTH = 4);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [7:0]       in_data;
  logic [2:0]       in_data_bits;
  logic             in_valid;
  logic             in_ready;
  logic             out_data;
  logic             out_data_valid;
  logic             out_last_bit_in_byte;
  logic             out_req;
  logic [LVL_W-1:0] level;

  modport master (
    output in_data, in_data_bits, in_valid, out_req,
    input  in_ready, out_data, out_data_valid, out_last_bit_in_byte, level
  );

  modport slave (
    input  in_data, in_data_bits, in_valid, out_req,
    output in_ready, out_data, out_data_valid, out_last_bit_in_byte, level
  );
endinterface

// File: rtl/tx_fifo_serialiser_sync_fifo.sv
// Single-clock FIFO with registered occupancy; caller guarantees no push when full, no pop when empty.
module sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    level_d = level_q + LVL_W'(push) - LVL_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: pointers and level define what is valid.
  always_ff @(posedge clk) mem_q <= mem_d;

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
endmodule

// File: rtl/tx_fifo_serialiser.sv
// Buffered byte-to-bit Tx serialiser: FIFO in front, req-paced bit output with optional odd parity.
module tx_fifo_serialiser
  import tx_fifo_serialiser_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ADD_PARITY = 1,
  parameter int MSB_FIRST  = 0
) (
  input logic                 clk,
  input logic                 rst_n,
  tx_fifo_serialiser_if.slave bus
);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [LVL_W-1:0] fifo_level;
  tx_byte_t         in_byte, fifo_rdata;

  ser_state_e state_q, state_d;
  logic [2:0] idx_q, idx_d;
  tx_byte_t   cur_q, cur_d;
  logic       out_data_q, out_data_d, valid_q, valid_d, last_q, last_d;
  logic       load, end_byte;

  function automatic logic [2:0] first_idx(input logic [2:0] bits);
    logic [3:0] n;
    n = bits_to_count(bits);
    return (MSB_FIRST != 0) ? 3'(n - 4'd1) : 3'd0;
  endfunction

  function automatic logic is_last(input logic [2:0] idx, input logic [2:0] bits);
    logic [3:0] n;
    n = bits_to_count(bits);
    return (MSB_FIRST != 0) ? (idx == 3'd0) : ({1'b0, idx} == n - 4'd1);
  endfunction

  assign in_byte   = '{data: bus.in_data, bits: bus.in_data_bits};
  assign fifo_push = bus.in_valid && bus.in_ready;

  sync_fifo #(.WIDTH(TX_BYTE_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (in_byte),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cur_d    = cur_q;
    valid_d  = valid_q;
    fifo_pop = 1'b0;
    load     = 1'b0;
    end_byte = 1'b0;
    case (state_q)
      S_IDLE:   load = !fifo_empty;
      S_BITS: if (bus.out_req) begin
        if (!is_last(idx_q, cur_q.bits))
          idx_d = (MSB_FIRST != 0) ? idx_q - 3'd1 : idx_q + 3'd1;
        else if (ADD_PARITY != 0 && cur_q.bits == 3'd0)
          state_d = S_PARITY;
        else
          end_byte = 1'b1;
      end
      S_PARITY: end_byte = bus.out_req;
      default:  state_d = S_IDLE;
    endcase
    if (end_byte) begin
      if (!fifo_empty) load = 1'b1;
      else begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    end
    // Loading directly from end-of-byte keeps consecutive bytes gapless.
    if (load) begin
      fifo_pop = 1'b1;
      cur_d    = fifo_rdata;
      idx_d    = first_idx(fifo_rdata.bits);
      state_d  = S_BITS;
      valid_d  = 1'b1;
    end
    out_data_d = 1'b0;
    last_d     = 1'b0;
    if (state_d == S_PARITY) begin
      out_data_d = ~^cur_d.data;
      last_d     = 1'b1;
    end else if (state_d == S_BITS) begin
      out_data_d = cur_d.data[idx_d];
      last_d     = is_last(idx_d, cur_d.bits) && !(ADD_PARITY != 0 && cur_d.bits == 3'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cur_q      <= '0;
      out_data_q <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cur_q      <= cur_d;
      out_data_q <= out_data_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
    end
  end

  assign bus.in_ready             = !fifo_full;
  assign bus.level                = fifo_level;
  assign bus.out_data             = out_data_q;
  assign bus.out_data_valid       = valid_q;
  assign bus.out_last_bit_in_byte = last_q;
endmodule

// File: tb/tb_tx_fifo_serialiser.sv
// Scoreboard bench: dut_a is LSB-first with parity and a level/valid model; dut_b is MSB-first.
module tb_tx_fifo_serialiser;
  import tx_fifo_serialiser_pkg::*;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tx_fifo_serialiser_if #(.DEPTH(DEPTH)) ifa ();
  tx_fifo_serialiser_if #(.DEPTH(DEPTH)) ifb ();

  tx_fifo_serialiser #(.DEPTH(DEPTH), .ADD_PARITY(1), .MSB_FIRST(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa));
  tx_fifo_serialiser #(.DEPTH(DEPTH), .ADD_PARITY(1), .MSB_FIRST(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb));

  logic req_a = 1'b0, poke_a = 1'b0, req_b = 1'b0;
  assign ifa.out_req = req_a | poke_a;
  assign ifb.out_req = req_b;

  int checks = 0, errors = 0;
  logic [1:0] q_a[$];
  logic [1:0] q_b[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Expected {bit,last} sequence; parity only on full bytes.
  task automatic gen(input logic [7:0] d, input logic [2:0] b, input bit msb,
                     output logic [8:0] bv, output logic [8:0] lv, output int n);
    int cnt, pos;
    cnt = (b == 3'd0) ? 8 : int'(b);
    bv = '0; lv = '0; n = 0;
    for (int i = 0; i < cnt; i++) begin
      pos   = msb ? cnt - 1 - i : i;
      bv[n] = d[pos];
      lv[n] = (i == cnt - 1) && (b != 3'd0);
      n++;
    end
    if (b == 3'd0) begin
      bv[n] = ~(^d);
      lv[n] = 1'b1;
      n++;
    end
  endtask

  // Reference model of dut_a occupancy and busy (expected out_data_valid).
  int lvl_m = 0;
  bit busy_m = 1'b0, req_last_a = 1'b0, rst_seen = 1'b0;
  bit req_e = 1'b0, rst_e = 1'b0;
  always @(posedge clk) begin
    bit m_push, m_pop, m_end;
    req_e = ifa.out_req;
    rst_e = rst_n;
    if (!rst_n) begin
      lvl_m = 0; busy_m = 1'b0; rst_seen = 1'b1;
    end else begin
      m_push = ifa.in_valid && (lvl_m < DEPTH);
      m_end  = busy_m && ifa.out_req && req_last_a;
      m_pop  = (lvl_m > 0) && (!busy_m || m_end);
      if (m_pop) busy_m = 1'b1;
      else if (m_end) busy_m = 1'b0;
      lvl_m = lvl_m + int'(m_push) - int'(m_pop);
    end
  end

  logic [2:0] snap = '0;
  bit snap_ok = 1'b0, saw_full = 1'b0;
  always @(negedge clk) begin
    if (rst_seen) begin
      if (snap_ok && snap[0] && !req_e && rst_e)
        chk("hold", 32'({ifa.out_data, ifa.out_last_bit_in_byte, ifa.out_data_valid}), 32'(snap));
      chk("valid", 32'(ifa.out_data_valid), 32'(busy_m));
      chk("level", 32'(ifa.level), lvl_m);
      chk("in_ready", 32'(ifa.in_ready), 32'(lvl_m < DEPTH));
      if (!ifa.in_ready) saw_full = 1'b1;
      snap    = {ifa.out_data, ifa.out_last_bit_in_byte, ifa.out_data_valid};
      snap_ok = 1'b1;
    end
  end

  int gap_lo = 1, gap_hi = 1, gap_cnt = 0, gap_tgt = 1, bits_seen = 0;
  bit sink_en = 1'b1;
  initial begin
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (sink_en && rst_n && ifa.out_data_valid === 1'b1) begin
        if (gap_cnt < gap_tgt) gap_cnt++;
        else begin
          if (q_a.size() == 0) begin
            chk("a_extra_bit", 32'd1, 32'd0);
            e = 2'b00;
          end else begin
            e = q_a.pop_front();
            chk("a_bit", 32'({ifa.out_data, ifa.out_last_bit_in_byte}), 32'(e));
          end
          req_last_a = e[0];
          req_a = 1'b1;
          @(negedge clk);
          req_a = 1'b0;
          bits_seen++;
          gap_cnt = 0;
          gap_tgt = $urandom_range(gap_hi, gap_lo);
        end
      end
    end
  end

  initial begin
    logic [1:0] e;
    int gb;
    gb = 0;
    forever begin
      @(negedge clk);
      if (rst_n && ifb.out_data_valid === 1'b1) begin
        if (gb < 2) gb++;
        else begin
          if (q_b.size() == 0) begin
            chk("b_extra_bit", 32'd1, 32'd0);
            e = 2'b00;
          end else begin
            e = q_b.pop_front();
            chk("b_bit", 32'({ifb.out_data, ifb.out_last_bit_in_byte}), 32'(e));
          end
          req_b = 1'b1;
          @(negedge clk);
          req_b = 1'b0;
          if (e[0] && q_b.size() > 0) chk("b_gapless", 32'(ifb.out_data_valid), 32'd1);
          gb = 0;
        end
      end
    end
  end

  task automatic set_gap(input int lo, input int hi);
    gap_lo = lo; gap_hi = hi;
    gap_cnt = 0;
    gap_tgt = $urandom_range(hi, lo);
  endtask

  // Called at a negedge; returns at the negedge after acceptance, leaving in_valid high.
  task automatic push_a(input logic [7:0] d, input logic [2:0] b);
    logic [8:0] bv, lv;
    int n, t;
    ifa.in_data = d; ifa.in_data_bits = b; ifa.in_valid = 1'b1;
    t = 0;
    while (!ifa.in_ready && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20000) chk("push_timeout", 32'd0, 32'd1);
    else begin
      gen(d, b, 1'b0, bv, lv, n);
      for (int i = 0; i < n; i++) q_a.push_back({bv[i], lv[i]});
    end
    @(negedge clk);
  endtask

  task automatic push_b(input logic [7:0] d);
    logic [8:0] bv, lv;
    int n;
    ifb.in_data = d; ifb.in_data_bits = 3'd0; ifb.in_valid = 1'b1;
    gen(d, 3'd0, 1'b1, bv, lv, n);
    for (int i = 0; i < n; i++) q_b.push_back({bv[i], lv[i]});
    @(negedge clk);
  endtask

  task automatic drain_a(input string tag);
    int t;
    t = 0;
    while ((q_a.size() != 0 || busy_m || lvl_m != 0) && t < 40000) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 32'(t < 40000), 32'd1);
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_ready"}, 32'(ifa.in_ready), 32'd1);
    chk({tag, "_level"}, 32'(ifa.level), 32'd0);
    chk({tag, "_outs"}, 32'({ifa.out_data, ifa.out_data_valid, ifa.out_last_bit_in_byte}), 32'd0);
  endtask

  initial begin
    int b0, t;
    ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.in_data_bits = '0;
    ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.in_data_bits = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_a("rst");
    rst_n = 1'b1;

    // MSB-first pair on dut_b, running alongside the first dut_a case
    push_b(8'hA5);
    push_b(8'h3C);
    ifb.in_valid = 1'b0;

    // All-zero full byte, slow sink: eight zeros then parity 1
    set_gap(126, 126);
    push_a(8'h00, 3'd0);
    ifa.in_valid = 1'b0;
    drain_a("drain_zero");
    chk("b_drained", q_b.size(), 32'd0);
    chk("b_level", 32'(ifb.level), 32'd0);

    // Partial byte: three bits, no parity
    set_gap(3, 3);
    push_a(8'h0B, 3'd3);
    ifa.in_valid = 1'b0;
    drain_a("drain_partial");

    // Overfill with a slow sink
    set_gap(60, 60);
    saw_full = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) push_a(8'(8'h31 * (i + 1)), 3'd0);
    ifa.in_valid = 1'b0;
    drain_a("drain_full");
    chk("saw_full", 32'(saw_full), 32'd1);

    // Reset during the 4th bit with two bytes still queued
    set_gap(40, 40);
    b0 = bits_seen;
    push_a(8'h5A, 3'd0);
    push_a(8'hC3, 3'd0);
    push_a(8'h81, 3'd0);
    ifa.in_valid = 1'b0;
    t = 0;
    while (bits_seen < b0 + 3 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("reach_4th_bit", 32'(t < 5000), 32'd1);
    sink_en = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    q_a.delete();
    chk_reset_a("midrst");
    @(negedge clk);
    set_gap(3, 3);
    sink_en = 1'b1;
    push_a(8'h96, 3'd0);
    ifa.in_valid = 1'b0;
    drain_a("drain_after_rst");

    // req while idle must not disturb anything
    poke_a = 1'b1;
    @(negedge clk);
    poke_a = 1'b0;
    chk("idle_req", 32'({ifa.out_data, ifa.out_data_valid, ifa.out_last_bit_in_byte}), 32'd0);
    @(negedge clk);
    chk("idle_req2", 32'(ifa.out_data_valid), 32'd0);

    // Random bytes and random req spacing
    set_gap(3, 198);
    for (int i = 0; i < 30; i++) begin
      logic [2:0] rb;
      repeat ($urandom_range(0, 20)) @(negedge clk);
      rb = ($urandom_range(0, 1) == 1) ? 3'd0 : 3'($urandom_range(1, 7));
      push_a(8'($urandom_range(0, 255)), rb);
      ifa.in_valid = 1'b0;
    end
    drain_a("drain_random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
